// File: rtl/fetcher_pkg.sv
// rtl/fetcher_pkg.sv - shared fetch-stage types and constants
package fetcher_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    DONE = 2'd2
  } fetch_state_t;

  localparam logic [31:0] INSTR_NOP = 32'h0000_0013;

endpackage

// File: rtl/fetcher.sv
// rtl/fetcher.sv - instruction fetch stage with fixed memory latency and redirect
// Optional misaligned-pc trap to NOP when FETCH_MISALIGN_CHECK_EN is defined.
module fetcher
  import fetcher_pkg::*;
#(
  parameter int unsigned MEM_LATENCY = 1,
  parameter int unsigned ADDR_WIDTH  = 15
) (
  input  logic                  clk,
  input  logic                  rstn,
  input  logic                  enabled,
  input  logic [31:0]           pc,
  output logic                  mem_en,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  input  logic [31:0]           mem_rdata,
  output logic                  completed,
  output logic [31:0]           instr_raw,
  output logic [31:0]           pc_out,
  output logic                  misaligned
);

  localparam logic [2:0] LAT = 3'(MEM_LATENCY);

  fetch_state_t          state_q;
  logic [2:0]            cnt_q;
  logic                  mem_en_q;
  logic                  done_q;
  logic [ADDR_WIDTH-1:0] mem_addr_q;
  logic [31:0]           instr_raw_q;
  logic [31:0]           pc_out_q;

  // Upper pc bits alias away by design; low bits only matter for the trap.
  logic unused_pc_bits;
  assign unused_pc_bits = ^{pc[31:ADDR_WIDTH+2], pc[1:0]};

`ifdef FETCH_MISALIGN_CHECK_EN
  logic misaligned_q;
  logic skip_q;
  logic misalign_req;
  assign misalign_req = (pc[1:0] != 2'b00);
  assign misaligned   = misaligned_q;
`else
  assign misaligned   = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (!rstn) begin
      state_q     <= IDLE;
      cnt_q       <= 3'd0;
      mem_en_q    <= 1'b0;
      done_q      <= 1'b0;
      mem_addr_q  <= '0;
      instr_raw_q <= 32'd0;
      pc_out_q    <= 32'd0;
`ifdef FETCH_MISALIGN_CHECK_EN
      misaligned_q <= 1'b0;
      skip_q       <= 1'b0;
`endif
    end else if (enabled) begin
      // A new request always wins, which also discards any read still in flight.
      pc_out_q   <= pc;
      mem_addr_q <= pc[ADDR_WIDTH+1:2];
      done_q     <= 1'b0;
      state_q    <= WAIT;
`ifdef FETCH_MISALIGN_CHECK_EN
      mem_en_q     <= !misalign_req;
      skip_q       <= misalign_req;
      misaligned_q <= 1'b0;
      cnt_q        <= misalign_req ? 3'd0 : LAT;
`else
      mem_en_q <= 1'b1;
      cnt_q    <= LAT;
`endif
    end else begin
      case (state_q)
        WAIT: begin
          mem_en_q <= 1'b0;
          if (cnt_q == 3'd0) begin
`ifdef FETCH_MISALIGN_CHECK_EN
            instr_raw_q  <= skip_q ? INSTR_NOP : mem_rdata;
            misaligned_q <= skip_q;
`else
            instr_raw_q <= mem_rdata;
`endif
            done_q  <= 1'b1;
            state_q <= DONE;
          end else begin
            cnt_q <= cnt_q - 3'd1;
          end
        end
        default: ;
      endcase
    end
  end

  assign mem_en    = mem_en_q;
  assign mem_addr  = mem_addr_q;
  assign instr_raw = instr_raw_q;
  assign pc_out    = pc_out_q;
  assign completed = done_q & !enabled;

endmodule

// File: tb/tb_fetcher.sv
// tb/tb_fetcher.sv - scoreboard bench for fetcher at MEM_LATENCY 1 and 3
module tb_fetcher;
  import fetcher_pkg::*;

  logic        clk = 1'b0;
  logic        rstn = 1'b0;
  logic        enabled = 1'b0;
  logic [31:0] pc = 32'd0;
  int          cyc = 0;
  int          n_vec = 0;
  int          n_err = 0;

  logic        mem_en1, mem_en3, cmp1, cmp3, mis1, mis3;
  logic [14:0] addr1, addr3;
  logic [31:0] rd1, rd3, instr1, instr3, pco1, pco3;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  fetcher #(.MEM_LATENCY(1), .ADDR_WIDTH(15)) u_dut1 (
    .clk(clk), .rstn(rstn), .enabled(enabled), .pc(pc),
    .mem_en(mem_en1), .mem_addr(addr1), .mem_rdata(rd1),
    .completed(cmp1), .instr_raw(instr1), .pc_out(pco1), .misaligned(mis1)
  );

  fetcher #(.MEM_LATENCY(3), .ADDR_WIDTH(15)) u_dut3 (
    .clk(clk), .rstn(rstn), .enabled(enabled), .pc(pc),
    .mem_en(mem_en3), .mem_addr(addr3), .mem_rdata(rd3),
    .completed(cmp3), .instr_raw(instr3), .pc_out(pco3), .misaligned(mis3)
  );

  function automatic logic [31:0] mem_word(input logic [14:0] a);
    case (a)
      15'd16:  return 32'h00A0_0093;
      15'd32:  return 32'h0000_0513;
      default: return 32'hC0DE_0000 | {17'd0, a};
    endcase
  endfunction

  // Memory: samples mem_en at an edge, data valid at the LAT-th following edge.
  logic [31:0] p1;
  logic [31:0] p3 [3];
  always @(posedge clk) begin
    p1    <= mem_en1 ? mem_word(addr1) : 32'hDEAD_0001;
    p3[0] <= mem_en3 ? mem_word(addr3) : 32'hDEAD_0003;
    p3[1] <= p3[0];
    p3[2] <= p3[1];
  end
  assign rd1 = p1;
  assign rd3 = p3[2];

  typedef struct {
    logic [31:0] instr;
    logic [31:0] pc;
    int          cyc;
  } exp_t;
  exp_t q1[$];
  exp_t q3[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic check_done(input int lat, input logic [31:0] instr, input logic [31:0] pco);
    exp_t e;
    if ((lat == 1 && q1.size() == 0) || (lat == 3 && q3.size() == 0)) begin
      n_vec++;
      n_err++;
      $display("FAIL unexpected_completion L%0d: instr %h pc %h at cycle %0d", lat, instr, pco, cyc);
      return;
    end
    e = (lat == 1) ? q1.pop_front() : q3.pop_front();
    check($sformatf("L%0d_instr_raw", lat), instr, e.instr);
    check($sformatf("L%0d_pc_out", lat), pco, e.pc);
    check($sformatf("L%0d_done_cycle", lat), 32'(cyc), 32'(e.cyc));
  endtask

  logic prev1 = 1'b0;
  logic prev3 = 1'b0;
  always @(negedge clk) begin
    if (rstn) begin
      if (cmp1 && !prev1) check_done(1, instr1, pco1);
      if (cmp3 && !prev3) check_done(3, instr3, pco3);
    end
    prev1 = cmp1;
    prev3 = cmp3;
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_on(input logic [31:0] a, output int e);
    enabled = 1'b1;
    pc      = a;
    e       = cyc + 1;
  endtask

  task automatic expect_both(input logic [31:0] instr, input logic [31:0] p, input int c1, input int c3);
    q1.push_back('{instr: instr, pc: p, cyc: c1});
    q3.push_back('{instr: instr, pc: p, cyc: c3});
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_mem_en1"}, {31'd0, mem_en1}, 32'd0);
    check({tag, "_mem_addr1"}, {17'd0, addr1}, 32'd0);
    check({tag, "_completed1"}, {31'd0, cmp1}, 32'd0);
    check({tag, "_instr1"}, instr1, 32'd0);
    check({tag, "_pc_out1"}, pco1, 32'd0);
    check({tag, "_misaligned1"}, {31'd0, mis1}, 32'd0);
    check({tag, "_completed3"}, {31'd0, cmp3}, 32'd0);
    check({tag, "_instr3"}, instr3, 32'd0);
  endtask

  initial begin
    int e, e2;
    repeat (3) step();
    check_all_zero("reset");
    rstn = 1'b1;
    step();

    // Reset two cycles into a fetch: nothing may ever be captured.
    pulse_on(32'h0000_0100, e);
    step(); enabled = 1'b0;
    step(); rstn = 1'b0;
    step(); step(); rstn = 1'b1;
    repeat (8) step();
    check_all_zero("reset_mid_wait");

    // Basic fetch.
    pulse_on(32'h0000_0040, e);
    expect_both(32'h00A0_0093, 32'h40, e + 2, e + 4);
    step(); enabled = 1'b0;
    check("basic_mem_en", {31'd0, mem_en1}, 32'd1);
    check("basic_mem_addr", {17'd0, addr1}, 32'h10);
    repeat (8) step();

    // Redirect one cycle after the first request.
    pulse_on(32'h0000_0040, e);
    step();
    pulse_on(32'h0000_0080, e2);
    expect_both(32'h0000_0513, 32'h80, e2 + 2, e2 + 4);
    step(); enabled = 1'b0;
    repeat (8) step();

    // Back-to-back: second request in the cycle completion would rise (L1).
    pulse_on(32'h0000_0040, e);
    step(); enabled = 1'b0;
    step(); step();
    pulse_on(32'h0000_0080, e2);
    expect_both(32'h0000_0513, 32'h80, e2 + 2, e2 + 4);
    #1;
    check("b2b_completed_masked", {31'd0, cmp1}, 32'd0);
    step(); enabled = 1'b0;
    repeat (8) step();

    // Misaligned pc.
    pulse_on(32'h0000_0042, e);
`ifdef FETCH_MISALIGN_CHECK_EN
    expect_both(INSTR_NOP, 32'h42, e + 1, e + 1);
    step(); enabled = 1'b0;
    check("misalign_mem_en", {31'd0, mem_en1}, 32'd0);
    repeat (6) step();
    check("misalign_flag1", {31'd0, mis1}, 32'd1);
    check("misalign_flag3", {31'd0, mis3}, 32'd1);
`else
    expect_both(32'h00A0_0093, 32'h42, e + 2, e + 4);
    step(); enabled = 1'b0;
    check("misalign_mem_en", {31'd0, mem_en1}, 32'd1);
    check("misalign_mem_addr", {17'd0, addr1}, 32'h10);
    repeat (6) step();
    check("misalign_flag1", {31'd0, mis1}, 32'd0);
`endif

    // Address wrap: bit 17 falls outside the 15-bit word address.
    pulse_on(32'h0002_0080, e);
    expect_both(32'h0000_0513, 32'h0002_0080, e + 2, e + 4);
    step(); enabled = 1'b0;
    check("wrap_mem_addr", {17'd0, addr1}, 32'h20);
    repeat (6) step();
    check("wrap_misaligned_cleared", {31'd0, mis1}, 32'd0);

    // Top of address space.
    pulse_on(32'hFFFF_FFFC, e);
    expect_both(32'hC0DE_7FFF, 32'hFFFF_FFFC, e + 2, e + 4);
    step(); enabled = 1'b0;
    check("top_mem_addr", {17'd0, addr1}, 32'h7FFF);
    repeat (8) step();

    check("L1_pending_expectations", 32'(q1.size()), 32'd0);
    check("L3_pending_expectations", 32'(q3.size()), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
